counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 126 ++++++++++++
 tb/tb_counter_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter for two requesters that
// sequences a shared external step-2 counter.
module counter_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [2:0] steps0,
  input  logic [2:0] steps1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [3:0] result,
  output logic       cnt_load_en,
  output logic       cnt_updown,
  output logic [3:0] cnt_load,
  input  logic [3:0] cnt_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    FINISH
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       win;
  logic [1:0] win_op;
  logic [3:0] win_data;
  logic [2:0] win_steps;

  logic       dir_q;
  logic [3:0] data_q;
  logic [2:0] rem_q;
  logic       id_q;
  logic       last_q;
  logic [3:0] res_q;

  // On a tie the requester not granted last time wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  assign win_op    = win ? op1 : op0;
  assign win_data  = win ? data1 : data0;
  assign win_steps = win ? steps1 : steps0;

  // Counter sits in hold mode unless LOAD or STEP overrides it.
  always_comb begin
    state_nxt   = state;
    gnt         = 2'b00;
    done        = 1'b0;
    cnt_load_en = 1'b1;
    cnt_load    = cnt_count;
    cnt_updown  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00 && !rst) begin
          gnt = win ? 2'b10 : 2'b01;
          if (win_op == 2'b01)
            state_nxt = LOAD;
          else if (win_op[1] && win_steps != 3'd0)
            state_nxt = STEP;
          else
            state_nxt = FINISH;
        end
      end
      LOAD: begin
        cnt_load  = data_q;
        state_nxt = FINISH;
      end
      STEP: begin
        cnt_load_en = 1'b0;
        cnt_updown  = dir_q;
        if (rem_q == 3'd1)
          state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dir_q  <= 1'b0;
      data_q <= 4'd0;
      rem_q  <= 3'd0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      res_q  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (gnt != 2'b00) begin
        dir_q  <= ~win_op[0];
        data_q <= win_data;
        rem_q  <= win_steps;
        id_q   <= win;
        last_q <= win;
      end else if (state == STEP) begin
        rem_q <= rem_q - 3'd1;
      end
      if (state == FINISH)
        res_q <= cnt_count;
    end
  end

  assign busy    = (state != IDLE);
  assign done_id = id_q;
  assign result  = (state == FINISH) ? cnt_count : res_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: external step-2 counter, a
// transaction-level model checked every cycle, plus directed literals.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] op0;
  logic [1:0] op1;
  logic [3:0] data0;
  logic [3:0] data1;
  logic [2:0] steps0;
  logic [2:0] steps1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       done_id;
  logic [3:0] result;
  logic       cnt_load_en;
  logic       cnt_updown;
  logic [3:0] cnt_load;
  logic [3:0] cnt_count;

  logic       preset_en = 1'b0;
  logic [3:0] preset_val = 4'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .op1(op1),
    .data0(data0), .data1(data1),
    .steps0(steps0), .steps1(steps1),
    .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .result(result),
    .cnt_load_en(cnt_load_en),
    .cnt_updown(cnt_updown),
    .cnt_load(cnt_load),
    .cnt_count(cnt_count)
  );

  // The shared counter: no reset, no enable, load or +/-2 each clock.
  always @(posedge clk) begin
    if (preset_en)
      cnt_count <= preset_val;
    else if (cnt_load_en)
      cnt_count <= cnt_load;
    else if (cnt_updown)
      cnt_count <= cnt_count + 4'd2;
    else
      cnt_count <= cnt_count - 4'd2;
  end

  // Directed literal expectations for the current cycle.
  logic       e_gnt_v = 0;
  logic [1:0] e_gnt = 0;
  logic       e_done_v = 0;
  logic       e_done = 0;
  logic       e_id = 0;
  logic [3:0] e_res = 0;
  logic       e_cnt_v = 0;
  logic [3:0] e_cnt = 0;
  logic       e_drv_v = 0;
  logic       e_le = 0;
  logic [3:0] e_ld = 0;
  logic       e_ud = 0;
  logic       e_busy_v = 0;
  logic       e_busy = 0;

  // Transaction model state.
  int         m_rem = 0;
  logic       m_last = 1'b1;
  logic [3:0] m_res = 4'd0;
  logic       m_id = 1'b0;
  int         m_kind = 0;
  logic [3:0] m_data = 4'd0;
  logic       m_dir = 1'b0;
  logic [3:0] m_exp = 4'd0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_hold();
    chk("hold_le", 32'(cnt_load_en), 32'd1);
    chk("hold_ld", 32'(cnt_load), 32'(cnt_count));
    chk("hold_ud", 32'(cnt_updown), 32'd0);
  endtask

  always @(negedge clk) begin
    logic       w;
    logic [1:0] xg;
    logic [1:0] wop;
    logic [3:0] wd;
    logic [2:0] ws;
    logic [3:0] delta;
    if (rst) begin
      m_rem  = 0;
      m_last = 1'b1;
      m_res  = 4'd0;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_id", 32'(done_id), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk_hold();
    end else if (m_rem == 0) begin
      xg = 2'b00;
      if (req == 2'b11)
        w = ~m_last;
      else
        w = (req == 2'b10);
      if (req != 2'b00) begin
        xg    = w ? 2'b10 : 2'b01;
        wop   = w ? op1 : op0;
        wd    = w ? data1 : data0;
        ws    = w ? steps1 : steps0;
        delta = {ws, 1'b0};
        m_last = w;
        m_id   = w;
        m_data = wd;
        m_dir  = ~wop[0];
        if (wop == 2'b01) begin
          m_kind = 1;
          m_rem  = 2;
          m_exp  = wd;
        end else if (wop[1] && ws != 3'd0) begin
          m_kind = 2;
          m_rem  = int'(ws) + 1;
          m_exp  = m_dir ? cnt_count + delta
                         : cnt_count - delta;
        end else begin
          m_kind = 0;
          m_rem  = 1;
          m_exp  = cnt_count;
        end
      end
      chk("gnt", 32'(gnt), 32'(xg));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_result", 32'(result), 32'(m_res));
      chk_hold();
    end else begin
      chk("busy_gnt", 32'(gnt), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(m_rem == 1));
      if (m_rem == 1) begin
        m_res = m_exp;
        chk("done_id", 32'(done_id), 32'(m_id));
        chk("result", 32'(result), 32'(m_exp));
        chk_hold();
      end else begin
        chk("run_result", 32'(result), 32'(m_res));
        if (m_kind == 1) begin
          chk("load_le", 32'(cnt_load_en), 32'd1);
          chk("load_ld", 32'(cnt_load), 32'(m_data));
        end else begin
          chk("step_le", 32'(cnt_load_en), 32'd0);
          chk("step_ud", 32'(cnt_updown), 32'(m_dir));
        end
      end
      m_rem = m_rem - 1;
    end
    if (e_gnt_v)
      chk("lit_gnt", 32'(gnt), 32'(e_gnt));
    if (e_busy_v)
      chk("lit_busy", 32'(busy), 32'(e_busy));
    if (e_cnt_v)
      chk("lit_cnt", 32'(cnt_count), 32'(e_cnt));
    if (e_done_v) begin
      chk("lit_done", 32'(done), 32'(e_done));
      chk("lit_result", 32'(result), 32'(e_res));
      if (e_done)
        chk("lit_id", 32'(done_id), 32'(e_id));
    end
    if (e_drv_v) begin
      chk("lit_le", 32'(cnt_load_en), 32'(e_le));
      chk("lit_ud", 32'(cnt_updown), 32'(e_ud));
      if (e_le)
        chk("lit_ld", 32'(cnt_load), 32'(e_ld));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    e_gnt_v   = 0;
    e_done_v  = 0;
    e_cnt_v   = 0;
    e_drv_v   = 0;
    e_busy_v  = 0;
    preset_en = 0;
  endtask

  task automatic x_gnt(input logic [1:0] g);
    e_gnt_v = 1; e_gnt = g;
  endtask

  task automatic x_done(input logic d, input logic id,
                        input logic [3:0] r);
    e_done_v = 1; e_done = d; e_id = id; e_res = r;
  endtask

  task automatic x_cnt(input logic [3:0] v);
    e_cnt_v = 1; e_cnt = v;
  endtask

  task automatic x_drv(input logic le, input logic [3:0] ld,
                       input logic ud);
    e_drv_v = 1; e_le = le; e_ld = ld; e_ud = ud;
  endtask

  task automatic x_busy(input logic b);
    e_busy_v = 1; e_busy = b;
  endtask

  task automatic preset(input logic [3:0] v);
    preset_en = 1; preset_val = v;
    cyc();
  endtask

  initial begin
    rst = 1; req = 0; op0 = 0; op1 = 0;
    data0 = 0; data1 = 0; steps0 = 0; steps1 = 0;
    preset_en = 1; preset_val = 4'd5;
    @(posedge clk);
    #1;
    preset_en = 0;
    x_gnt(2'b00); x_done(0, 0, 4'd0); x_busy(0);
    x_cnt(4'd5); x_drv(1, 4'd5, 0);
    cyc();

    // Load 9 over counter 5.
    rst = 0; req = 2'b01; op0 = 2'b01; data0 = 4'd9;
    x_gnt(2'b01); x_cnt(4'd5);
    cyc();
    req = 0; op0 = 2'b11; data0 = 4'd3;
    x_gnt(2'b00); x_busy(1); x_drv(1, 4'd9, 0); x_cnt(4'd5);
    cyc();
    x_done(1, 0, 4'd9); x_cnt(4'd9); x_drv(1, 4'd9, 0);
    cyc();
    x_done(0, 0, 4'd9); x_busy(0);
    cyc();

    // Count up 3 steps from 9.
    req = 2'b10; op1 = 2'b10; steps1 = 3'd3;
    x_gnt(2'b10); x_cnt(4'd9);
    cyc();
    req = 0; op1 = 2'b11; steps1 = 3'd7;
    for (int k = 0; k < 3; k++) begin
      x_drv(0, 4'd0, 1); x_cnt(4'(9 + 2 * k));
      x_done(0, 0, 4'd9);
      cyc();
    end
    x_done(1, 1, 4'd15); x_cnt(4'd15);
    cyc();
    x_done(0, 0, 4'd15);
    cyc();

    // Wrap up: 14 + 2*2 = 2.
    preset(4'd14);
    req = 2'b01; op0 = 2'b10; steps0 = 3'd2;
    x_gnt(2'b01); x_cnt(4'd14);
    cyc();
    req = 0;
    x_drv(0, 4'd0, 1); x_cnt(4'd14);
    cyc();
    x_drv(0, 4'd0, 1); x_cnt(4'd0);
    cyc();
    x_done(1, 0, 4'd2); x_cnt(4'd2);
    cyc();

    // Wrap down: 1 - 2 = 15.
    preset(4'd1);
    req = 2'b10; op1 = 2'b11; steps1 = 3'd1;
    x_gnt(2'b10); x_cnt(4'd1);
    cyc();
    req = 0;
    x_drv(0, 4'd0, 0); x_cnt(4'd1);
    cyc();
    x_done(1, 1, 4'd15); x_cnt(4'd15);
    cyc();

    // Both requesting nops after reset: strict alternation.
    rst = 1; req = 2'b11; op0 = 2'b00; op1 = 2'b00;
    x_gnt(2'b00); x_done(0, 0, 4'd0); x_busy(0);
    cyc();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      x_gnt((i % 2 == 1) ? 2'b10 : 2'b01); x_busy(0);
      cyc();
      x_gnt(2'b00); x_busy(1);
      x_done(1, (i % 2 == 1), 4'd15);
      cyc();
    end
    req = 0;
    x_gnt(2'b00); x_busy(0);
    cyc();

    // Zero steps: immediate done, counter held.
    preset(4'd6);
    req = 2'b01; op0 = 2'b10; steps0 = 3'd0;
    x_gnt(2'b01); x_cnt(4'd6); x_drv(1, 4'd6, 0);
    cyc();
    req = 0;
    x_done(1, 0, 4'd6); x_cnt(4'd6); x_drv(1, 4'd6, 0);
    cyc();
    x_cnt(4'd6); x_busy(0);
    cyc();

    // Reset after the first of four up steps.
    preset(4'd9);
    req = 2'b10; op1 = 2'b10; steps1 = 3'd4;
    x_gnt(2'b10); x_cnt(4'd9);
    cyc();
    req = 0;
    x_drv(0, 4'd0, 1); x_cnt(4'd9);
    cyc();
    rst = 1;
    x_drv(1, 4'd11, 0); x_cnt(4'd11);
    x_done(0, 0, 4'd0); x_busy(0);
    cyc();
    x_drv(1, 4'd11, 0); x_cnt(4'd11);
    x_done(0, 0, 4'd0); x_busy(0);
    cyc();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      x_cnt(4'd11); x_done(0, 0, 4'd0);
      x_busy(0); x_gnt(2'b00);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
